// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the fetch PC, issues in-order instruction reads over a valid/ready
// request channel and hands returned instructions, tagged with their PC and fault status,
// to the core over a valid/ready output channel. A redirect restarts fetch at a new PC and
// discards every older in-flight or buffered instruction.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   redirect_valid, redirect_pc   restart fetch at redirect_pc (bits [1:0] forced to 0)
//   imem_req_valid/ready/addr     instruction memory read request
//   imem_rsp_valid/data/err       in-order read response, never back-pressured
//   out_valid/ready/inst/pc/fault instruction handed to the core
module inst_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  localparam int unsigned     PW  = $clog2(DEPTH);
  localparam int unsigned     CW  = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] INC = XLEN'(ILEN / 8);

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [ILEN-1:0]  r_inst [DEPTH];
  logic [DEPTH-1:0] r_fault;
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_fill;   // oldest reserved-but-unfilled entry
  logic [CW-1:0]    r_count;  // reserved entries, filled or not
  logic [CW-1:0]    r_pend;   // reserved entries still waiting for data
  logic [CW-1:0]    r_drop;   // responses still owed to requests killed by a redirect

  logic             w_pop;
  logic             w_accept;
  logic             w_fill;
  logic             w_rsp_drop;
  logic             w_rsp_any;
  logic [CW:0]      w_occ;
  logic [CW:0]      w_inflight;
  logic [CW:0]      w_drop_redir;
  logic [DEPTH-1:0] w_filled_d;
  logic             w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  assign out_valid = rst & (r_count != '0) & r_filled[r_head];
  assign w_pop     = out_valid & out_ready;

  // Credits cover both live entries and responses still owed for dropped requests; a slot
  // freed by this cycle's pop may be reused immediately.
  assign w_occ          = {1'b0, r_count} + {1'b0, r_drop} - {{CW{1'b0}}, w_pop};
  assign imem_req_valid = rst & ~redirect_valid & (w_occ < (CW + 1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid & (r_drop != '0);
  assign w_fill     = imem_rsp_valid & (r_drop == '0) & (r_pend != '0);

  // On redirect every unfilled entry becomes a drop; a response arriving in the same cycle
  // settles one of them.
  assign w_inflight   = {1'b0, r_pend} + {1'b0, r_drop};
  assign w_rsp_any    = imem_rsp_valid & (w_inflight != '0);
  assign w_drop_redir = w_inflight - {{CW{1'b0}}, w_rsp_any};

  assign out_inst  = out_valid ? r_inst[r_head]  : '0;
  assign out_pc    = out_valid ? r_pc[r_head]    : '0;
  assign out_fault = out_valid ? r_fault[r_head] : 1'b0;

  always_comb begin
    w_filled_d = r_filled;
    if (w_pop)    w_filled_d[r_head] = 1'b0;
    if (w_accept) w_filled_d[r_tail] = 1'b0;
    if (w_fill)   w_filled_d[r_fill] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_filled   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= w_drop_redir[CW-1:0];
      r_filled   <= '0;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + INC;
        r_tail     <= r_tail + PW'(1);
      end
      if (w_pop)      r_head <= r_head + PW'(1);
      if (w_fill)     r_fill <= r_fill + PW'(1);
      if (w_rsp_drop) r_drop <= r_drop - CW'(1);
      r_count  <= r_count + CW'(w_accept) - CW'(w_pop);
      r_pend   <= r_pend + CW'(w_accept) - CW'(w_fill);
      r_filled <= w_filled_d;
    end
  end

  // Payload storage needs no reset: it is only visible through a filled head entry.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pc[r_tail] <= r_fetch_pc;
    end
    if (w_fill && rst && !redirect_valid) begin
      r_inst[r_fill]  <= imem_rsp_data;
      r_fault[r_fill] <= imem_rsp_err;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (r_pend != '0 || r_drop != '0))
    else $error("imem response with nothing outstanding");

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit (IFU) that sits directly upstream of the core's decode/execute datapath. It owns the fetch PC and issues in-order instruction reads to instruction memory over a valid/ready request channel. Each returned instruction is buffered with its PC and handed to the core over a valid/ready output channel. A redirect input from the execute stage restarts fetch at a new PC and discards all older in-flight and buffered instructions.

## Interface

- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 32'h80000000, first fetch address after reset
- DEPTH, 2, buffer entries; maximum requests in flight plus buffered instructions (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the clock edge)
- redirect_valid  in  1  restart fetch; single-cycle pulse
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address (fetch_pc)
- imem_rsp_valid  in  1  read data valid; responses in request order, ≥1 cycle after acceptance, never back-pressured
- imem_rsp_data  in  ILEN  instruction word
- imem_rsp_err  in  1  access fault for this response
- out_valid  out  1  instruction available to core
- out_ready  in  1  core consumes instruction
- out_inst  out  ILEN  instruction
- out_pc  out  XLEN  PC of out_inst
- out_fault  out  1  out_inst came from a faulting access

## Operation

- State: fetch_pc; circular buffer of DEPTH entries {pc, inst, fault, filled} with head/tail pointers and count; drop counter (width clog2(DEPTH+1)).
- Slot allocation: an entry is reserved at tail on request acceptance, storing pc = fetch_pc with filled=0.
- Responses fill the oldest unfilled entry, setting inst, fault, and filled=1.
- Credit rule: imem_req_valid = rst & !redirect_valid & (count − pop + drop < DEPTH).
  - pop = out_valid & out_ready.
  - A slot freed by a pop is therefore reusable for a request in the same cycle.
- Request accept (valid & ready): fetch_pc += ILEN/8, with 32-bit wrap-around (32'hFFFFFFFC → 0).
- Output: out_valid = head entry filled. out_inst, out_pc, and out_fault come from the head entry. A pop advances head.
- Redirect (takes effect at the clock edge):
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - All buffer entries are invalidated (count=0, head=tail).
  - drop ← number of reserved-but-unfilled entries + current drop − (1 if a response arrives this cycle).
  - An output handshake in the redirect cycle is honoured; the core has consumed that instruction.
  - No request is issued in the redirect cycle.
- Drop: while drop>0, each imem_rsp_valid decrements drop and its data is discarded. Dropped responses still occupy credits until they arrive.
- Faults do not stall fetch. A faulting entry is delivered like any other, and the core is expected to redirect.
- imem_req_valid/imem_req_addr stay stable until accepted, except on redirect, where the request is withdrawn. The memory side tolerates a withdrawn request.
- Response arriving with no unfilled entry and drop=0: protocol violation; the response is ignored and the simulation assertion fires.

## Timing

- Reset values (rst=0 at the edge): fetch_pc=RESET_PC, count=0, drop=0, pointers=0.
- Output values while rst=0: imem_req_valid=0 and out_valid=0. out_inst, out_pc, and out_fault read 0 when out_valid=0.
- Reset mid-operation clears everything. Responses to pre-reset requests are not expected; memory resets alongside.
- First request: the first cycle with rst=1. imem_req_addr=RESET_PC.
- Latency: a response accepted in cycle N with the entry at head gives out_valid=1 in cycle N+1 (registered buffer).
- Throughput: with 1-cycle memory latency, DEPTH=2, and out_ready held high, 1 instruction/cycle steady state.
- Full: when count+drop=DEPTH with no pop, imem_req_valid=0.
- Empty: out_valid=0, and out_ready has no effect.
- Simultaneous events in one cycle are handled in this priority: redirect > request accept > pop/fill (pop and fill both applied).

## Test plan

- Reset release, memory ready with 1-cycle latency, out_ready=1 → requests 80000000, 80000004, 80000008…; out_pc follows in order, first out_valid 2 cycles after rst rises, then 1 instruction/cycle.
- out_ready=0 for 10 cycles → exactly 2 requests outstanding/buffered, imem_req_valid=0. Release out_ready → 80000000 then 80000004 delivered, fetch resumes at 80000008.
- Redirect to 80001002 while 2 requests are in flight → next request address 80001000; both old responses discarded (drop 2→0); first out_pc=80001000.
- Redirect in the same cycle as an output handshake and a response → handshake counted once; that response dropped; no stale out_pc afterwards.
- imem_rsp_err=1 on the response for 80000004 → out_fault=1 only on that instruction; fetch continues at 80000008.
- Random imem_req_ready/rsp latency (1–5 cycles) with random redirects → scoreboard: out_pc sequence contiguous (+4) between redirects, with no drops or duplicates.
